alarm_timer: RTL

Memory-mapped compare/alarm peripheral sitting directly downstream of the free-running clock counter peripheral. It watches the counter's current value, raises a pending flag and an interrupt request when the counter reaches a programmed compare value, and optionally re-arms itself periodically. The CPU programs and services it over the same simple register bus used by the other peripherals.

---
 rtl/alarm_timer_if.sv | 23 ++
 rtl/alarm_timer.sv | 119 +++++++++++
 2 files changed

// File: rtl/alarm_timer_if.sv
// Register-bus and counter-tap bundle for the alarm_timer compare peripheral.
// The master side drives the bus and the counter value; the slave returns read data and irq.
interface alarm_timer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] din;
    logic             wen;
    logic             cs;
    logic [WIDTH-1:0] dout;
    logic             irq;

    modport master (
        output cnt, addr, din, wen, cs,
        input  dout, irq
    );

    modport slave (
        input  cnt, addr, din, wen, cs,
        output dout, irq
    );
endinterface

// File: rtl/alarm_timer.sv
// Compare/alarm peripheral: pends and interrupts on the rising edge of cnt == CMP, optional periodic re-arm.
// Latency: irq one clk after the equality cycle; reads are combinational and there is no backpressure.
module alarm_timer #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    alarm_timer_if.slave  bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_CMP    = 2'd1;
    localparam logic [1:0] A_PERIOD = 2'd2;
    localparam logic [1:0] A_STAT   = 2'd3;

    state_t           state, state_nxt;
    logic             per, per_nxt;
    logic             ie, ie_nxt;
    logic [WIDTH-1:0] cmp, cmp_nxt;
    logic [WIDTH-1:0] period, period_nxt;
    logic             pnd, pnd_nxt;
    logic             ovr, ovr_nxt;
    logic             match, match_d;
    logic             fire;
    logic             wr;
    logic             en;
    logic             unused_addr;

    assign unused_addr = ^bus.addr[WIDTH-1:2];

    assign wr    = bus.cs & bus.wen;
    assign en    = (state == ARMED);
    assign match = (bus.cnt == cmp);
    assign fire  = en & match & ~match_d;

    always_comb begin
        state_nxt  = state;
        per_nxt    = per;
        ie_nxt     = ie;
        cmp_nxt    = cmp;
        period_nxt = period;
        pnd_nxt    = pnd;
        ovr_nxt    = ovr;

        case (state)
            IDLE:  state_nxt = IDLE;
            ARMED: if (fire && !per) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (fire && per)
            cmp_nxt = cmp + period;

        if (wr && bus.addr[1:0] == A_STAT) begin
            if (bus.din[0]) pnd_nxt = 1'b0;
            if (bus.din[1]) ovr_nxt = 1'b0;
        end

        // A clear landing on the fire edge counts as serviced first, so it is not an overrun.
        if (fire) begin
            pnd_nxt = 1'b1;
            if (pnd && !(wr && bus.addr[1:0] == A_STAT && bus.din[0]))
                ovr_nxt = 1'b1;
        end

        // CPU writes override same-cycle hardware updates of EN and CMP.
        if (wr) begin
            case (bus.addr[1:0])
                A_CTRL: begin
                    state_nxt = bus.din[0] ? ARMED : IDLE;
                    per_nxt   = bus.din[1];
                    ie_nxt    = bus.din[2];
                end
                A_CMP:    cmp_nxt    = bus.din;
                A_PERIOD: period_nxt = bus.din;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            per     <= 1'b0;
            ie      <= 1'b0;
            cmp     <= '0;
            period  <= '0;
            pnd     <= 1'b0;
            ovr     <= 1'b0;
            match_d <= 1'b0;
        end else begin
            state   <= state_nxt;
            per     <= per_nxt;
            ie      <= ie_nxt;
            cmp     <= cmp_nxt;
            period  <= period_nxt;
            pnd     <= pnd_nxt;
            ovr     <= ovr_nxt;
            match_d <= match;
        end
    end

    always_comb begin
        bus.dout = '0;
        case (bus.addr[1:0])
            A_CTRL:   bus.dout = {{(WIDTH-5){1'b0}}, ovr, pnd, ie, per, en};
            A_CMP:    bus.dout = cmp;
            A_PERIOD: bus.dout = period;
            A_STAT:   bus.dout = {{(WIDTH-2){1'b0}}, ovr, pnd};
            default:  bus.dout = '0;
        endcase
    end

    assign bus.irq = pnd & ie;
endmodule
